// File: rtl/sdc_dma_arbiter.sv
// Two-master Wishbone arbiter sharing the memory slave between the CPU (m0) and the SD DMA (m1).
// Round-robin grant per cyc envelope; define SDC_ARB_TIMEOUT_EN to add the no-ack watchdog (ABORT state).
module sdc_dma_arbiter #(
    parameter int unsigned TIMEOUT_W      = 16,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,

    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_dout,
    output logic [31:0] m0_din,
    input  logic [3:0]  m0_dm,
    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    output logic        m0_ack,
    output logic        m0_err,

    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_dout,
    output logic [31:0] m1_din,
    input  logic [3:0]  m1_dm,
    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    output logic        m1_ack,
    output logic        m1_err,

    output logic [31:0] s_addr,
    output logic [31:0] s_dout,
    input  logic [31:0] s_din,
    output logic [3:0]  s_dm,
    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    input  logic        s_ack,

    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2
`ifdef SDC_ARB_TIMEOUT_EN
        ,
        ST_ABORT = 2'd3
`endif
    } state_e;

    state_e     state_q;
    state_e     state_d;
    logic       last_q;     // 0: m0 owned the bus last, 1: m1 owned it last
    logic [1:0] grant_q;

    if (TIMEOUT_W < 2 || TIMEOUT_CYCLES < 16'd2) begin : g_bad_cfg
        $error("sdc_dma_arbiter: TIMEOUT_W and TIMEOUT_CYCLES must both be at least 2");
    end

`ifdef SDC_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 16'd1);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 m0_err_q;
    logic                 m1_err_q;
    logic                 timeout_hit;

    assign timeout_hit = s_stb && !s_ack && (cnt_q == TO_LAST);
    assign m0_err      = m0_err_q;
    assign m1_err      = m1_err_q;
`else
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

    assign grant = grant_q;

    // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
    always_comb begin
        s_addr = '0;
        s_dout = '0;
        s_dm   = '0;
        s_we   = 1'b0;
        s_stb  = 1'b0;
        s_cyc  = 1'b0;
        m0_ack = 1'b0;
        m1_ack = 1'b0;
        m0_din = '0;
        m1_din = '0;
        case (state_q)
            ST_OWN0: begin
                s_addr = m0_addr;
                s_dout = m0_dout;
                s_dm   = m0_dm;
                s_we   = m0_we;
                s_stb  = m0_stb;
                s_cyc  = m0_cyc;
                m0_ack = s_ack;
                m0_din = s_din;
            end
            ST_OWN1: begin
                s_addr = m1_addr;
                s_dout = m1_dout;
                s_dm   = m1_dm;
                s_we   = m1_we;
                s_stb  = m1_stb;
                s_cyc  = m1_cyc;
                m1_ack = s_ack;
                m1_din = s_din;
            end
            default: ;
        endcase
    end

    // A new owner is chosen only from IDLE, which forces one idle cycle between any two cyc envelopes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc) begin
                    state_d = ST_OWN0;
                end else if (m1_cyc) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc) begin
                    state_d = ST_IDLE;
                end
`ifdef SDC_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = ST_ABORT;
                end
`endif
            end
            ST_OWN1: begin
                if (!m1_cyc) begin
                    state_d = ST_IDLE;
                end
`ifdef SDC_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = ST_ABORT;
                end
`endif
            end
`ifdef SDC_ARB_TIMEOUT_EN
            ST_ABORT: begin
                if (!(last_q ? m1_cyc : m0_cyc)) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: registers update with non-blocking assignments; the combinational blocks above use blocking.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            grant_q  <= 2'b00;
`ifdef SDC_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;

            if (state_d == ST_OWN0) begin
                last_q <= 1'b0;
            end else if (state_d == ST_OWN1) begin
                last_q <= 1'b1;
            end

            case (state_d)
                ST_OWN0:  grant_q <= 2'b01;
                ST_OWN1:  grant_q <= 2'b10;
`ifdef SDC_ARB_TIMEOUT_EN
                ST_ABORT: grant_q <= grant_q;
`endif
                default:  grant_q <= 2'b00;
            endcase

`ifdef SDC_ARB_TIMEOUT_EN
            // Saturating wait counter: restarts on any ownership change or acknowledge.
            if ((state_d != state_q) || s_ack) begin
                cnt_q <= '0;
            end else if (s_stb && (cnt_q != '1)) begin
                cnt_q <= cnt_q + TIMEOUT_W'(1);
            end

            m0_err_q <= (state_d == ST_ABORT) && (state_q != ST_ABORT) && !last_q;
            m1_err_q <= (state_d == ST_ABORT) && (state_q != ST_ABORT) && last_q;
`endif
        end
    end

endmodule

// File: tb/tb_sdc_dma_arbiter.sv
// Directed testbench for sdc_dma_arbiter: reset, tie arbitration, unsplit DMA burst, round robin,
// watchdog (with SDC_ARB_TIMEOUT_EN) or wait-forever (without), and reset in the middle of a burst.
module tb_sdc_dma_arbiter;

`ifdef SDC_ARB_TIMEOUT_EN
    localparam logic [15:0] TB_TIMEOUT = 16'd8;
`else
    localparam logic [15:0] TB_TIMEOUT = 16'd4096;
`endif
    localparam logic [31:0] DIN_KEY = 32'hA5A5_0000;

    logic        wb_clk;
    logic        wb_rst_n;
    logic [31:0] m0_addr, m0_dout, m0_din;
    logic [3:0]  m0_dm;
    logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
    logic [31:0] m1_addr, m1_dout, m1_din;
    logic [3:0]  m1_dm;
    logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
    logic [31:0] s_addr, s_dout, s_din;
    logic [3:0]  s_dm;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [1:0]  grant;

    logic        slave_en;
    int          n_vec;
    int          n_miss;
    int          acks;

    // Zero-wait slave: acknowledges every strobed beat in the same cycle, read data derived from address.
    assign s_ack = slave_en & s_cyc & s_stb;
    assign s_din = s_addr ^ DIN_KEY;

    sdc_dma_arbiter #(
        .TIMEOUT_W      (16),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .m0_addr  (m0_addr),
        .m0_dout  (m0_dout),
        .m0_din   (m0_din),
        .m0_dm    (m0_dm),
        .m0_cyc   (m0_cyc),
        .m0_stb   (m0_stb),
        .m0_we    (m0_we),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m1_addr  (m1_addr),
        .m1_dout  (m1_dout),
        .m1_din   (m1_din),
        .m1_dm    (m1_dm),
        .m1_cyc   (m1_cyc),
        .m1_stb   (m1_stb),
        .m1_we    (m1_we),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .s_addr   (s_addr),
        .s_dout   (s_dout),
        .s_din    (s_din),
        .s_dm     (s_dm),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_we     (s_we),
        .s_ack    (s_ack),
        .grant    (grant)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input bit m, input bit cyc, input logic [31:0] addr,
                         input bit we, input logic [31:0] dout);
        if (m) begin
            m1_cyc  = cyc;
            m1_stb  = cyc;
            m1_addr = addr;
            m1_we   = we;
            m1_dout = dout;
            m1_dm   = 4'hF;
        end else begin
            m0_cyc  = cyc;
            m0_stb  = cyc;
            m0_addr = addr;
            m0_we   = we;
            m0_dout = dout;
            m0_dm   = 4'hF;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".grant"},  32'(grant),  32'd0);
        check({tag, ".s_cyc"},  32'(s_cyc),  32'd0);
        check({tag, ".s_stb"},  32'(s_stb),  32'd0);
        check({tag, ".s_we"},   32'(s_we),   32'd0);
        check({tag, ".s_addr"}, s_addr,      32'd0);
        check({tag, ".s_dout"}, s_dout,      32'd0);
        check({tag, ".s_dm"},   32'(s_dm),   32'd0);
        check({tag, ".m0_ack"}, 32'(m0_ack), 32'd0);
        check({tag, ".m1_ack"}, 32'(m1_ack), 32'd0);
        check({tag, ".m0_din"}, m0_din,      32'd0);
        check({tag, ".m1_din"}, m1_din,      32'd0);
        check({tag, ".m0_err"}, 32'(m0_err), 32'd0);
        check({tag, ".m1_err"}, 32'(m1_err), 32'd0);
    endtask

    // Master m is expected to own the bus with cyc/stb high and address addr on the slave side.
    task automatic check_own(input string tag, input bit m, input logic [31:0] addr);
        check({tag, ".grant"},     32'(grant), m ? 32'd2 : 32'd1);
        check({tag, ".s_cyc"},     32'(s_cyc), 32'd1);
        check({tag, ".s_stb"},     32'(s_stb), 32'd1);
        check({tag, ".s_addr"},    s_addr,     addr);
        check({tag, ".ack"},       32'(m ? m1_ack : m0_ack), 32'(slave_en));
        check({tag, ".other_ack"}, 32'(m ? m0_ack : m1_ack), 32'd0);
        check({tag, ".din"},       m ? m1_din : m0_din,      addr ^ DIN_KEY);
        check({tag, ".other_din"}, m ? m0_din : m1_din,      32'd0);
    endtask

    task automatic run_owner(input bit m, input logic [31:0] base, input int beats, input string tag);
        for (int i = 0; i < beats; i++) begin
            set_m(m, 1'b1, base + 32'(4 * i), 1'b0, 32'(i));
            settle();
            check_own(tag, m, base + 32'(4 * i));
            tick();
        end
    endtask

    logic [12:0] rr_m0;
    logic [12:0] rr_m1;
    logic [1:0]  rr_grant [13];
    logic        exp_cyc;

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        slave_en = 1'b1;
        rr_m0    = 13'b0000011111011;
        rr_m1    = 13'b0011111011110;
        rr_grant = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0};

        // Reset held 3 cycles with both masters requesting.
        wb_rst_n = 1'b0;
        set_m(1'b0, 1'b1, 32'h0000_1000, 1'b1, 32'hDEAD_0000);
        set_m(1'b1, 1'b1, 32'h0000_8000, 1'b0, 32'h0);
        repeat (3) tick();
        settle();
        check_idle("reset");
        wb_rst_n = 1'b1;
        tick();
        settle();
        check_own("rst_first", 1'b0, 32'h0000_1000);
        check("rst_first.s_we",   32'(s_we), 32'd1);
        check("rst_first.s_dout", s_dout,    32'hDEAD_0000);
        check("rst_first.s_dm",   32'(s_dm), 32'hF);
        set_m(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        set_m(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        settle();
        check_idle("rst_drop");

        // Fresh reset so the tie starts from last=1.
        wb_rst_n = 1'b0;
        tick();
        wb_rst_n = 1'b1;

        // Tie: both raise cyc together; m0 first, m1 two cycles after m0 releases.
        set_m(1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0);
        set_m(1'b1, 1'b1, 32'h0000_8000, 1'b0, 32'h0);
        settle();
        check_idle("tie_req");
        tick();
        run_owner(1'b0, 32'h0000_1000, 4, "tie_m0");
        set_m(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        settle();
        check("tie_rel.s_cyc", 32'(s_cyc), 32'd0);
        check("tie_rel.grant", 32'(grant), 32'd1);
        tick();
        settle();
        check_idle("tie_gap");
        tick();
        run_owner(1'b1, 32'h0000_8000, 4, "tie_m1");
        set_m(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        settle();
        check_idle("tie_end");

        // 128-word DMA write burst; m0 starts requesting at beat 3 and must wait.
        set_m(1'b1, 1'b1, 32'h0000_2000, 1'b1, 32'h0);
        tick();
        acks = 0;
        for (int i = 0; i < 128; i++) begin
            set_m(1'b1, 1'b1, 32'h0000_2000 + 32'(4 * i), 1'b1, 32'(i));
            if (i == 3) set_m(1'b0, 1'b1, 32'h0000_1100, 1'b0, 32'h0);
            settle();
            check_own("burst", 1'b1, 32'h0000_2000 + 32'(4 * i));
            check("burst.s_dout", s_dout,    32'(i));
            check("burst.s_we",   32'(s_we), 32'd1);
            acks += int'(m1_ack);
            tick();
        end
        set_m(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        settle();
        check("burst.acks",  32'(acks),  32'd128);
        check("burst.s_cyc", 32'(s_cyc), 32'd0);
        tick();
        settle();
        check("burst.gap_grant", 32'(grant), 32'd0);
        tick();
        settle();
        check_own("burst_m0", 1'b0, 32'h0000_1100);
        set_m(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        settle();
        check_idle("burst_end");

        // Round robin: m0 re-requests back to back while m1 is pending.
        for (int r = 0; r < 13; r++) begin
            set_m(1'b0, rr_m0[r], 32'h0000_1200, 1'b0, 32'h0);
            set_m(1'b1, rr_m1[r], 32'h0000_8100, 1'b0, 32'h0);
            settle();
            exp_cyc = (rr_grant[r] == 2'd1) ? rr_m0[r] : (rr_grant[r] == 2'd2) ? rr_m1[r] : 1'b0;
            check($sformatf("rr[%0d].grant", r), 32'(grant), 32'(rr_grant[r]));
            check($sformatf("rr[%0d].s_cyc", r), 32'(s_cyc), 32'(exp_cyc));
            tick();
        end

`ifdef SDC_ARB_TIMEOUT_EN
        // Watchdog: slave never acks m1; err pulses 8 cycles after s_stb rose.
        slave_en = 1'b0;
        set_m(1'b1, 1'b1, 32'h0000_4000, 1'b0, 32'h0);
        tick();
        set_m(1'b0, 1'b1, 32'h0000_1300, 1'b0, 32'h0);
        settle();
        check("to.stb_rise", 32'(s_stb),  32'd1);
        check("to.err_0",    32'(m1_err), 32'd0);
        for (int k = 1; k < 8; k++) begin
            tick();
            settle();
            check($sformatf("to.wait[%0d].err", k), 32'(m1_err), 32'd0);
            check($sformatf("to.wait[%0d].stb", k), 32'(s_stb),  32'd1);
        end
        tick();
        settle();
        check("to.err",    32'(m1_err), 32'd1);
        check("to.m0_err", 32'(m0_err), 32'd0);
        check("to.s_cyc",  32'(s_cyc),  32'd0);
        check("to.s_stb",  32'(s_stb),  32'd0);
        check("to.m1_ack", 32'(m1_ack), 32'd0);
        check("to.grant",  32'(grant),  32'd2);
        slave_en = 1'b1;
        tick();
        settle();
        check("to.err_pulse", 32'(m1_err), 32'd0);
        check("to.hold",      32'(grant),  32'd2);
        check("to.hold_cyc",  32'(s_cyc),  32'd0);
        check("to.hold_ack",  32'(m1_ack), 32'd0);
        set_m(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        settle();
        check("to.idle", 32'(grant), 32'd0);
        tick();
        settle();
        check_own("to_m0", 1'b0, 32'h0000_1300);
        set_m(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
`else
        // Without the watchdog the arbiter waits indefinitely for the slave.
        slave_en = 1'b0;
        set_m(1'b1, 1'b1, 32'h0000_4000, 1'b0, 32'h0);
        tick();
        for (int k = 0; k < 20; k++) begin
            tick();
            settle();
            check($sformatf("wait[%0d].err", k),   32'(m1_err), 32'd0);
            check($sformatf("wait[%0d].grant", k), 32'(grant),  32'd2);
        end
        check("wait.stb", 32'(s_stb), 32'd1);
        slave_en = 1'b1;
        settle();
        check("wait.late_ack", 32'(m1_ack), 32'd1);
        set_m(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
`endif

        // Reset asserted on beat 10 of an m1 burst.
        set_m(1'b1, 1'b1, 32'h0000_3000, 1'b0, 32'h0);
        tick();
        run_owner(1'b1, 32'h0000_3000, 10, "mid");
        set_m(1'b1, 1'b1, 32'h0000_3028, 1'b0, 32'h0);
        wb_rst_n = 1'b0;
        settle();
        check_own("mid_beat10", 1'b1, 32'h0000_3028);
        tick();
        settle();
        check_idle("mid_rst");
        tick();
        settle();
        check_idle("mid_rst_hold");
        wb_rst_n = 1'b1;
        set_m(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sdc_dma_arbiter.md
# sdc_dma_arbiter

Two-master Wishbone arbiter that shares the system memory slave port between the CPU data master (m0) and the SD controller's DMA master (m1). It sits between the SD controller's `wbm_*` port and the memory bus, in the `wb_clk` domain. It grants round-robin per Wishbone cycle and holds the grant for the full `cyc` envelope, so DMA block bursts are never split. An optional watchdog aborts slave accesses that never acknowledge.

## Interface
Parameters:
- `TIMEOUT_W`, 16: width of the watchdog counter. Only used with `SDC_ARB_TIMEOUT_EN`.
- `TIMEOUT_CYCLES`, 16'd4096: number of cycles a strobed access may wait for `s_ack` before it is aborted.

Ports:
- `wb_clk` in 1: the only clock.
- `wb_rst_n` in 1: reset, synchronous, active-low.
- `m0_addr`, `m1_addr` in 32: master byte address.
- `m0_dout`, `m1_dout` in 32: master write data.
- `m0_din`, `m1_din` out 32: read data returned to the master.
- `m0_dm`, `m1_dm` in 4: byte select.
- `m0_cyc`, `m1_cyc`, `m0_stb`, `m1_stb`, `m0_we`, `m1_we` in 1: master Wishbone controls.
- `m0_ack`, `m1_ack` out 1: acknowledge to the master.
- `m0_err`, `m1_err` out 1: one-cycle pulse when the watchdog aborts that master's access.
- `s_addr` out 32, `s_dout` out 32, `s_din` in 32, `s_dm` out 4: slave-side Wishbone address, data and byte select.
- `s_cyc`, `s_stb`, `s_we` out 1: slave-side Wishbone controls.
- `s_ack` in 1: slave acknowledge.
- `grant` out 2: one-hot current owner (bit0 = m0, bit1 = m1). Used for debug and the SD busy LED.

## Operation
States: IDLE, OWN0, OWN1, ABORT.

- **Reset:** state=IDLE, `last`=1 (m0 wins the first tie). All outputs are 0: `s_cyc`, `s_stb`, `s_we`, `s_addr`, `s_dout`, `s_dm`, `m*_ack`, `m*_err`, `grant`.
- **IDLE:**
  - Only one `m*_cyc` asserted: go to that master's OWN state.
  - Both asserted: grant the master other than `last`.
  - Neither asserted: stay in IDLE.
  - All slave outputs are 0 while in IDLE.
- **OWNx:**
  - `s_addr`, `s_dout`, `s_dm`, `s_we`, `s_stb` equal master x's signals, combinationally.
  - `s_cyc` = `mx_cyc`.
  - `mx_ack` = `s_ack`. `mx_din` = `s_din`.
  - The other master sees ack=0, err=0 and `din`=0.
  - `grant` = one-hot x. `last` ← x on entry.
- **OWNx exit:** when `mx_cyc`=0, go to IDLE next cycle. `s_cyc` drops in the same cycle because it is combinational.
- **Arbitration gap:** a new grant is decided only from IDLE. There is always at least one IDLE cycle between owners, including back-to-back cycles by the same master.
- **Non-owner requests:** a non-owner may hold `cyc`/`stb` indefinitely. It receives nothing until granted.
- **ABORT** (only with `SDC_ARB_TIMEOUT_EN`): see Configuration.

## Timing
- **Grant latency:** `mx_cyc` rises in cycle N while IDLE → state OWNx and `s_cyc`/`s_stb` visible in cycle N+1.
- **Ack path:** `s_ack` to `mx_ack` is a zero-cycle combinational path; the arbiter adds no pipeline delay per beat.
- **Release:** master drops `cyc` in cycle K → IDLE in K+1 → the other pending master is granted (visible) in K+2.
- **Simultaneous release and request:**
  - Owner m0 drops `cyc` in cycle K while m1 is pending → m1 is granted in K+2.
  - m0 re-requesting in K+1 still loses to m1 because `last`=0.
- **Reset mid-transfer:** on `wb_rst_n`=0, state returns to IDLE next edge. Slave outputs are 0 from that edge, independent of master inputs.
- **Glitch-free ownership:** `grant` and all routing muxes change only on `wb_clk` edges, never within a cycle.

## Configuration
- **With `SDC_ARB_TIMEOUT_EN` defined:**
  - A `TIMEOUT_W`-bit counter clears on every state change and on every `s_ack`=1.
  - It increments each cycle in OWNx while `s_stb`=1 and `s_ack`=0.
  - When it reaches `TIMEOUT_CYCLES`-1 without an ack, the next cycle is ABORT:
    - `s_cyc`=`s_stb`=0.
    - `mx_err` pulses 1 for that first ABORT cycle only.
    - `mx_ack` stays 0.
  - ABORT holds until `mx_cyc`=0, then goes to IDLE.
  - A `s_ack` arriving during ABORT is discarded.
  - The counter saturates; it never wraps.
- **Without the macro:**
  - No counter and no ABORT state.
  - `m0_err` = `m1_err` = constant 0.
  - The arbiter waits forever for `s_ack`.

## Test plan
- **Reset:** hold `wb_rst_n`=0 for 3 cycles with both masters requesting → all outputs 0. After release, m0 is granted at the first post-reset edge +1, and `grant`=2'b01.
- **Tie arbitration:** m0 and m1 raise `cyc` in the same cycle, each doing 4 single reads with 1-cycle slave ack. Required: m0 granted first; m1 granted exactly 2 cycles after m0 drops `cyc`; addresses 0x1000 and 0x8000 never interleave on `s_addr`.
- **DMA burst not split:** m1 performs a 128-word burst (one `cyc`, data 0x0..0x7F) while m0 requests from beat 3 onward. Required: all 128 acks go to m1, `m0_ack` stays 0, and m0 is granted 2 cycles after m1 releases.
- **Round robin:** m0 issues back-to-back cycles while m1 is pending. Required: the grant sequence is m0, m1, m0, m1, with one IDLE cycle between owners.
- **Timeout** (`SDC_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8): slave never acks m1. Required: `m1_err` is high for exactly one cycle, 8 cycles after `s_stb` rose; `s_cyc` goes 0; m0 is granted only after m1 drops `cyc`.
- **Reset mid-burst:** assert `wb_rst_n`=0 on beat 10 of an m1 burst. Required: `s_cyc`=0 next edge, no further `m1_ack`, and state is IDLE.
